// File: rtl/preif_npc_gen_pkg.sv
// rtl/preif_npc_gen_pkg.sv - shared types and constants for the PRE-IF next-PC generator
package preif_npc_gen_pkg;

    localparam logic [31:0] EXC_VECTOR_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } npc_state_t;

    // Fetch-block base address: pc with the in-block byte offset cleared.
    function automatic logic [31:0] block_base(input logic [31:0] pc, input logic [31:0] fb_bytes);
        return pc & ~(fb_bytes - 32'd1);
    endfunction

endpackage

// File: rtl/preif_redirect_arb.sv
// rtl/preif_redirect_arb.sv - fixed-priority redirect selector, index 0 wins
module preif_redirect_arb #(
    parameter int NUM_REDIRECT = 4
) (
    input  logic [NUM_REDIRECT-1:0]    valid,
    input  logic [NUM_REDIRECT*32-1:0] target,
    output logic                       any,
    output logic [31:0]                sel_target
);

    // Scanning from the highest index down lets the lowest asserted index overwrite last.
    always_comb begin
        any        = 1'b0;
        sel_target = '0;
        for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
            if (valid[i]) begin
                any        = 1'b1;
                sel_target = target[i*32 +: 32];
            end
        end
    end

endmodule

// File: rtl/preif_npc_gen.sv
// rtl/preif_npc_gen.sv - PRE-IF fetch PC holder, redirect resolution and fetch-block request
module preif_npc_gen
    import preif_npc_gen_pkg::*;
#(
    parameter int          FETCH_WIDTH  = 2,
    parameter int          NUM_REDIRECT = 4,
    parameter int          EPOCH_W      = 3,
    parameter logic [31:0] RESET_PC     = EXC_VECTOR_PC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REDIRECT-1:0]    redirect_valid,
    input  logic [NUM_REDIRECT*32-1:0] redirect_target,
    input  logic                       bpu_valid,
    input  logic [31:0]                bpu_target,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [31:0]                req_pc,
    output logic [FETCH_WIDTH-1:0]     req_mask,
    output logic [EPOCH_W-1:0]         req_epoch,
    output logic                       req_except,
    output logic                       flush_out
);

    localparam logic [31:0] FB_BYTES = 32'(FETCH_WIDTH * 4);
    localparam logic [31:0] OFF_MASK = FB_BYTES - 32'd1;

    npc_state_t         state, state_next;
    logic [31:0]        pc, pc_next;
    logic [EPOCH_W-1:0] epoch;
    logic               redir_any;
    logic [31:0]        redir_target;
    logic               handshake;
    logic [31:0]        seq_next;
    logic [31:0]        slot;

    preif_redirect_arb #(
        .NUM_REDIRECT(NUM_REDIRECT)
    ) u_arb (
        .valid      (redirect_valid),
        .target     (redirect_target),
        .any        (redir_any),
        .sel_target (redir_target)
    );

    always_comb begin
        seq_next = block_base(pc, FB_BYTES) + FB_BYTES;
        slot     = (pc & OFF_MASK) >> 2;
    end

    always_comb begin
        req_valid  = 1'b0;
        req_except = 1'b0;
        state_next = state;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                req_valid  = !redir_any;
                req_except = (pc[1:0] != 2'b00);
                if (req_valid && req_ready && req_except)
                    state_next = HALT;
            end
            HALT: state_next = HALT;
            default: state_next = BOOT;
        endcase
        // A redirect overrides everything, including a same-cycle handshake.
        if (redir_any)
            state_next = RUN;
    end

    always_comb begin
        req_mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            req_mask[i] = !req_except && (32'(i) >= slot);
    end

    always_comb begin
        handshake = req_valid && req_ready;
        pc_next   = pc;
        if (redir_any)
            pc_next = redir_target;
        else if (handshake)
            pc_next = bpu_valid ? bpu_target : seq_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            epoch     <= '0;
            flush_out <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            flush_out <= redir_any;
            if (redir_any)
                epoch <= epoch + 1'b1;
        end
    end

    assign req_pc    = pc;
    assign req_epoch = epoch;

endmodule

// File: tb/tb_preif_npc_gen.sv
// tb/tb_preif_npc_gen.sv - randomized and directed bench for preif_npc_gen against a behavioural model
module tb_preif_npc_gen;

    localparam int          FW   = 2;
    localparam int          NR   = 4;
    localparam int          EW   = 3;
    localparam logic [31:0] BOOT_PC = 32'hBFC0_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    rv;
    logic [NR*32-1:0] rt;
    logic             bv;
    logic [31:0]      bt;
    logic             rdy;
    logic             req_valid;
    logic [31:0]      req_pc;
    logic [FW-1:0]    req_mask;
    logic [EW-1:0]    req_epoch;
    logic             req_except;
    logic             flush_out;

    preif_npc_gen #(
        .FETCH_WIDTH (FW),
        .NUM_REDIRECT(NR),
        .EPOCH_W     (EW),
        .RESET_PC    (BOOT_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (rv),
        .redirect_target(rt),
        .bpu_valid      (bv),
        .bpu_target     (bt),
        .req_valid      (req_valid),
        .req_ready      (rdy),
        .req_pc         (req_pc),
        .req_mask       (req_mask),
        .req_epoch      (req_epoch),
        .req_except     (req_except),
        .flush_out      (flush_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: fetch address, epoch count, and whether fetching is live / stopped.
    logic [31:0] m_pc;
    int          m_epoch;
    bit          m_started;
    bit          m_halted;
    bit          m_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int winner();
        for (int i = 0; i < NR; i++)
            if (rv[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pc = BOOT_PC; m_epoch = 0; m_started = 0; m_halted = 0; m_flush = 0;
    endtask

    task automatic set_rt(input int idx, input logic [31:0] t);
        rt[idx*32 +: 32] = t;
    endtask

    task automatic quiet();
        rv = '0; bv = 1'b0; rdy = 1'b0;
    endtask

    // Check all outputs against the model, then advance one clock and update the model.
    task automatic step();
        int          w;
        bit          live, exc, ev;
        logic [31:0] emask;
        int          first_slot;
        #1;
        w    = winner();
        live = m_started && !m_halted;
        exc  = live && (m_pc % 4 != 0);
        ev   = live && (w < 0);
        first_slot = int'((m_pc % (FW * 4)) / 4);
        emask = 0;
        if (!exc)
            for (int s = 0; s < FW; s++)
                if (s >= first_slot) emask[s] = 1'b1;
        check("req_valid",  32'(req_valid),  32'(ev));
        check("req_pc",     req_pc,          m_pc);
        check("req_mask",   32'(req_mask),   emask);
        check("req_epoch",  32'(req_epoch),  32'(m_epoch));
        check("req_except", 32'(req_except), 32'(exc));
        check("flush_out",  32'(flush_out),  32'(m_flush));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (w >= 0) begin
            m_pc      = rt[w*32 +: 32];
            m_epoch   = (m_epoch + 1) % (1 << EW);
            m_flush   = 1;
            m_started = 1;
            m_halted  = 0;
        end else begin
            m_flush = 0;
            if (!m_started) begin
                m_started = 1;
            end else if (ev && rdy) begin
                if (exc) m_halted = 1;
                m_pc = bv ? bt : (m_pc - (m_pc % (FW * 4)) + FW * 4);
            end
        end
        @(negedge clk);
    endtask

    task automatic redirect(input int idx, input logic [31:0] t);
        quiet();
        rv[idx] = 1'b1;
        set_rt(idx, t);
        step();
        rv = '0;
    endtask

    initial begin
        rst = 1'b1; rt = '0; bt = '0;
        quiet();
        model_reset();
        repeat (3) step();
        @(negedge clk);
        rst = 1'b0;

        // Boot sequence and sequential stream with ready tied high.
        rdy = 1'b1;
        step();
        check("boot_pc", req_pc, 32'hBFC0_0000);
        repeat (4) step();

        // Mid-block entry from the lowest-priority source.
        redirect(3, 32'hBFC0_0004);
        rdy = 1'b1;
        step();
        step();

        // Priority with a simultaneous ready.
        rv = 4'b0110; set_rt(1, 32'h8000_0000); set_rt(2, 32'h9000_0000); rdy = 1'b1;
        step();
        rv = '0;
        check("prio_pc", req_pc, 32'h8000_0000);
        step();
        step();

        // Backpressure with BPU toggling, then a predicted-taken handshake.
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bv = k[0]; bt = $urandom;
            step();
        end
        rdy = 1'b1; bv = 1'b1; bt = 32'h8000_1000;
        step();
        bv = 1'b0;
        check("bpu_pc", req_pc, 32'h8000_1000);
        step();

        // Misaligned target halts fetching until the next redirect.
        redirect(0, 32'h8000_0002);
        rdy = 1'b1;
        step();
        repeat (10) step();
        redirect(2, 32'h8000_0000);
        step();

        // Eight redirects wrap the 3-bit epoch.
        for (int k = 0; k < 8; k++)
            redirect(k % NR, {$urandom_range(32'hFFFF, 0), 16'h0000});
        step();

        // Sequential wrap across the top of the address space.
        redirect(1, 32'hFFFF_FFF8);
        rdy = 1'b1; bv = 1'b0;
        step();
        check("wrap_pc", req_pc, 32'h0000_0000);
        step();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NR; i++) begin
                rv[i] = ($urandom_range(15, 0) == 0);
                rt[i*32 +: 32] = ($urandom_range(7, 0) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            end
            rdy = $urandom_range(3, 0) != 0;
            bv  = $urandom_range(3, 0) == 0;
            bt  = $urandom & 32'hFFFF_FFFC;
            step();
        end

        // Asynchronous reset mid-operation.
        quiet();
        redirect(0, 32'h1234_5670);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 32'(req_valid), 32'd0);
        check("async_pc",    req_pc,         BOOT_PC);
        check("async_epoch", 32'(req_epoch), 32'd0);
        check("async_flush", 32'(flush_out), 32'd0);
        model_reset();
        @(negedge clk);
        step();
        @(negedge clk);
        rst = 1'b0;
        rdy = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
